// File: rtl/init_column_sequencer.sv
// Loads one column of N_ROWS node values from a combinational init LUT, scales
// each by an arithmetic right shift and writes it to the node memories.
module init_column_sequencer #(
    parameter int N_ROWS = 30,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 18
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [2:0]        shift,
    input  logic              abort,
    output logic [ADDR_W-1:0] lut_addr,
    input  logic [DATA_W-1:0] lut_data,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(N_ROWS - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [2:0]          shift_q, shift_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic signed [DATA_W-1:0] scaled;
    logic                slot_free;
    logic                fire;

    // Handshake: the output slot holds (mem_waddr, mem_wdata) while mem_we=1;
    // a write completes only on a cycle with mem_we=1 and mem_ready=1, and the
    // slot contents never change while mem_we=1 and mem_ready=0.
    assign fire      = we_q && mem_ready;
    assign slot_free = !we_q || mem_ready;
    assign scaled    = $signed(lut_data) >>> shift_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        we_d    = we_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                we_d = 1'b0;
                if (start) begin
                    state_d = S_FILL;
                    cnt_d   = '0;
                    shift_d = shift;
                end
            end
            S_FILL: begin
                if (abort) begin
                    state_d = S_IDLE;
                    we_d    = 1'b0;
                end else if (slot_free) begin
                    we_d    = 1'b1;
                    waddr_d = cnt_q;
                    wdata_d = scaled;
                    // Counter parks on the last row rather than running past it.
                    if (cnt_q == LAST_ROW) begin
                        state_d = S_DRAIN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    we_d    = 1'b0;
                end else if (fire) begin
                    state_d = S_DONE;
                    we_d    = 1'b0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                we_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign lut_addr    = (state_q == S_FILL) ? cnt_q : '0;
    assign mem_we      = we_q;
    assign mem_waddr   = waddr_q;
    assign mem_wdata   = wdata_q;
    assign busy        = (state_q == S_FILL) || (state_q == S_DRAIN);
    assign done        = (state_q == S_DONE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_init_column_sequencer.sv
// Directed bench for init_column_sequencer: LUT is a triangle peaking at 0x8000
// on rows 14/15, optionally negated; writes are scoreboarded against exp_q.
module tb_init_column_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [2:0]  shift;
    logic        abort;
    logic [9:0]  lut_addr;
    logic [17:0] lut_data;
    logic        mem_we;
    logic        mem_ready;
    logic [9:0]  mem_waddr;
    logic [17:0] mem_wdata;
    logic        busy;
    logic        done;
    logic [1:0]  dbg_state;
    logic        neg = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [27:0] exp_q[$];

    always #5 clk = ~clk;

    init_column_sequencer #(.N_ROWS(30), .ADDR_W(10), .DATA_W(18)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .shift(shift), .abort(abort),
        .lut_addr(lut_addr), .lut_data(lut_data), .mem_we(mem_we), .mem_ready(mem_ready),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
        .dbg_state_o(dbg_state)
    );

    function automatic logic [17:0] lut_val(input logic [9:0] a, input logic n);
        int v;
        if (a > 10'd29)      v = 0;
        else if (a < 10'd15) v = (int'(a) * 32768) / 14;
        else                 v = ((29 - int'(a)) * 32768) / 14;
        if (n) v = -v;
        return v[17:0];
    endfunction

    function automatic logic [17:0] exp_data(input int r, input int sh, input logic n);
        logic [9:0]  a;
        logic [17:0] raw;
        int v;
        a   = r[9:0];
        raw = lut_val(a, n);
        v   = int'($signed(raw));
        v   = v >>> sh;
        return v[17:0];
    endfunction

    assign lut_data = lut_val(lut_addr, neg);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int sh, input int stall_at, input int restart_at,
                           output logic [17:0] d7, output logic [17:0] d14);
        logic [27:0] e;
        int nw = 0;
        int nd = 0;
        int stalls = 0;
        bit prev_last = 0;
        d7 = '0;
        d14 = '0;
        for (int r = 0; r < 30; r++) exp_q.push_back({r[9:0], exp_data(r, sh, neg)});
        shift = sh[2:0];
        start = 1'b1;
        mem_ready = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("lut_addr_first", lut_addr, 0);
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (prev_last) chk("done_after_last", done, 1);
            if (done) begin
                nd++;
                chk("busy_in_done", busy, 0);
                break;
            end
            start = (restart_at >= 0 && nw == restart_at);
            if (mem_we && int'(mem_waddr) == stall_at && stalls < 5) begin
                mem_ready = 1'b0;
                stalls++;
                chk("stall_addr_held", mem_waddr, stall_at);
                chk("stall_data_held", mem_wdata, exp_data(stall_at, sh, neg));
            end else begin
                mem_ready = 1'b1;
            end
            prev_last = 0;
            if (mem_we && mem_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 28'hFFFFFFF;
                chk("write_addr_data", {mem_waddr, mem_wdata}, e);
                if (mem_waddr == 10'd7)  d7 = mem_wdata;
                if (mem_waddr == 10'd14) d14 = mem_wdata;
                nw++;
                prev_last = (mem_waddr == 10'd29);
            end
            step();
        end
        start = 1'b0;
        mem_ready = 1'b1;
        chk("write_count", nw, 30);
        chk("done_count", nd, 1);
        chk("exp_q_empty", exp_q.size(), 0);
        if (stall_at >= 0) chk("stall_cycles", stalls, 5);
        exp_q.delete();
        step();
        chk("done_one_cycle", done, 0);
        chk("back_to_idle", dbg_state, 0);
    endtask

    initial begin
        logic [17:0] d7, d14;
        bit found;
        reset_n = 1'b0;
        start = 1'b0;
        shift = 3'd0;
        abort = 1'b0;
        mem_ready = 1'b1;
        #2;
        chk("rst_mem_we", mem_we, 0);
        chk("rst_waddr", mem_waddr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_lut_addr", lut_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_state", dbg_state, 0);
        step();
        step();
        reset_n = 1'b1;
        step();
        chk("idle_after_release", dbg_state, 0);

        // Plain load, shift 0.
        do_load(0, -1, -1, d7, d14);
        chk("shift0_row14", d14, 18'h08000);
        chk("shift0_row7", d7, 18'h04000);

        // Shift 1.
        do_load(1, -1, -1, d7, d14);
        chk("shift1_row14", d14, 18'h04000);
        chk("shift1_row7", d7, 18'h02000);

        // Backpressure on row 10.
        do_load(0, 10, -1, d7, d14);

        // Start pulsed while busy.
        do_load(2, -1, 10, d7, d14);
        chk("shift2_row14", d14, 18'h02000);

        // Abort after row 5 is accepted.
        shift = 3'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 50; i++) begin
            if (mem_we && mem_waddr == 10'd5) begin
                found = 1;
                break;
            end
            step();
        end
        chk("abort_row5_seen", found, 1);
        step();
        abort = 1'b1;
        chk("abort_row6_pending", mem_we, 1);
        step();
        abort = 1'b0;
        chk("abort_we", mem_we, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_state", dbg_state, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abort_quiet_we", mem_we, 0);
            chk("abort_quiet_done", done, 0);
        end
        do_load(0, -1, -1, d7, d14);

        // Reset mid-load at row 20, then a negative-data load.
        start = 1'b1;
        step();
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 60; i++) begin
            if (mem_we && mem_waddr == 10'd20) begin
                found = 1;
                break;
            end
            step();
        end
        chk("reset_row20_seen", found, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_we", mem_we, 0);
        chk("midrst_waddr", mem_waddr, 0);
        chk("midrst_wdata", mem_wdata, 0);
        chk("midrst_lut_addr", lut_addr, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("postrst_idle", dbg_state, 0);
            chk("postrst_we", mem_we, 0);
        end
        neg = 1'b1;
        do_load(3, -1, -1, d7, d14);
        chk("neg_shift3_row14", d14, 18'h3F000);
        chk("neg_shift3_row7", d7, 18'h3F800);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/init_column_sequencer.md
INIT_COLUMN_SEQUENCER -- requirements
Module: init_column_sequencer

Interface
REQ-001 SHALL have parameter N_ROWS, default 30, number of node rows loaded per column.
REQ-002 SHALL have parameter ADDR_W, default 10, width of the LUT and memory row address.
REQ-003 SHALL have parameter DATA_W, default 18, node value width (signed fixed point).
REQ-004 Port clk  input  1  single clock; all state changes on the rising edge.
REQ-005 Port reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port start  input  1  request to load one column; sampled only in IDLE.
REQ-007 Port shift  input  3  arithmetic right-shift amplitude scale; captured when start is accepted.
REQ-008 Port abort  input  1  synchronous cancel of a load in progress.
REQ-009 Port lut_addr  output  ADDR_W  row address driven to the combinational init-value LUT.
REQ-010 Port lut_data  input  DATA_W  LUT value for lut_addr, valid in the same cycle.
REQ-011 Port mem_we  output  1  write-valid to the node memories (u_curr and u_prev).
REQ-012 Port mem_ready  input  1  memory accepts the write in this cycle.
REQ-013 Port mem_waddr  output  ADDR_W  row address of the pending write.
REQ-014 Port mem_wdata  output  DATA_W  scaled node value, written to both u_curr and u_prev.
REQ-015 Port busy  output  1  high from start acceptance until the DONE state is reached.
REQ-016 Port done  output  1  one-cycle pulse after the last row has been accepted.

Function
REQ-017 SHALL implement the states IDLE, FILL, DRAIN and DONE.
REQ-018 IDLE -> FILL when start=1; SHALL capture shift, clear the row counter to 0 and assert busy on the next edge.
REQ-019 In FILL, lut_addr SHALL equal the row counter; in IDLE and DONE, lut_addr SHALL be 0.
REQ-020 Output stage SHALL be a registered valid/ready slot; a write completes only on a cycle where mem_we=1 and mem_ready=1.
REQ-021 In FILL, when the slot is empty or completing this cycle, it SHALL load mem_waddr=counter and mem_wdata=lut_data >>> shift (sign-extended), set mem_we=1, and increment the counter.
REQ-022 When mem_we=1 and mem_ready=0, mem_we, mem_waddr, mem_wdata and the counter SHALL hold unchanged.
REQ-023 Latency: a row's address on lut_addr SHALL appear on mem_waddr/mem_we exactly 1 cycle later with no stall.
REQ-024 With mem_ready held high, the block SHALL issue N_ROWS consecutive writes, one per cycle, with addresses 0..N_ROWS-1 in order.
REQ-025 FILL -> DRAIN after the slot loads row N_ROWS-1; the counter SHALL NOT exceed N_ROWS-1.
REQ-026 DRAIN -> DONE when the last write completes; DONE SHALL pulse done=1 and busy=0 for one cycle, then return to IDLE.
REQ-027 start asserted while busy=1 or in DONE SHALL be ignored (no queuing).
REQ-028 abort=1 in FILL or DRAIN SHALL drop mem_we to 0 on the next edge, with no done pulse, and return to IDLE; abort SHALL take precedence over a simultaneous write completion.
REQ-029 shift=0 SHALL pass lut_data unmodified; a negative lut_data SHALL shift with sign preservation.

Reset
REQ-030 reset_n=0 SHALL immediately force IDLE, counter=0, mem_we=0, mem_waddr=0, mem_wdata=0, lut_addr=0, busy=0, done=0, and the captured shift=0.
REQ-031 Reset asserted mid-load SHALL abandon the load without issuing further writes; the first edge after release SHALL remain in IDLE unless start=1.

Verification
REQ-032 Reset, then start=1 with shift=0 and mem_ready=1 -> 30 writes, addr 0..29, data 0x00000, 0x00924, ..., 0x08000, 0x08000, ..., 0x00000; done pulses once, 1 cycle after the addr-29 write.
REQ-033 Start with shift=1 -> row 14 data 0x04000 and row 7 data 0x02000.
REQ-034 Start, then mem_ready=0 for 5 cycles during row 10 -> mem_waddr=10 and its data held stable; total writes 30, no skipped or duplicated addresses.
REQ-035 Abort after row 5 is accepted -> mem_we=0 next cycle, no done pulse, busy=0; a new start restarts from addr 0.
REQ-036 Start pulsed again while busy -> ignored; exactly one done pulse and 30 writes.
REQ-037 reset_n low at row 20 -> all outputs 0 immediately; no writes until the next start.
